// File: rtl/timer_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_counter_pkg
//  Purpose  : Shared encodings for the memory-mapped down-counter timer:
//             FSM states, mode codes, CTRL bit positions, register offsets.
//  Revision : 1.0  initial release
// ============================================================================
package timer_counter_pkg;

   // Timer FSM states
   typedef enum logic [1:0] {
      TIMER_IDLE = 2'd0,
      TIMER_LOAD = 2'd1,
      TIMER_CNT  = 2'd2,
      TIMER_INT  = 2'd3
   } timer_state_e;

   // Mode codes held in CTRL[2:1]; the reserved codes 1x behave as one-shot
   localparam logic [1:0] c_mode_oneshot = 2'b00;
   localparam logic [1:0] c_mode_reload  = 2'b01;

   // CTRL bit positions
   localparam int c_ctrl_en_bit   = 0;
   localparam int c_ctrl_mode_lsb = 1;
   localparam int c_ctrl_mode_msb = 2;
   localparam int c_ctrl_im_bit   = 3;
   localparam int c_ctrl_width    = 4;

   // Register word offsets, decoded from address[3:2]
   localparam logic [1:0] c_addr_ctrl   = 2'd0;
   localparam logic [1:0] c_addr_preset = 2'd1;
   localparam logic [1:0] c_addr_count  = 2'd2;

   // True when the mode field selects auto-reload
   function automatic logic is_reload_mode(input logic [1:0] mode);
      return (mode == c_mode_reload);
   endfunction

endpackage : timer_counter_pkg
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module   : timer_counter
//  Purpose  : Programmable 32-bit down-counter peripheral with CTRL, PRESET
//             and COUNT registers. Raises irq when the count expires and the
//             interrupt mask bit in CTRL is set. One-shot and auto-reload.
//  Revision : 1.0  initial release
// ============================================================================
module timer_counter
   import timer_counter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        writeEnable,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        irq
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   timer_state_e              r_state;
   logic [c_ctrl_width-1:0]   r_ctrl;
   logic [31:0]               r_preset;
   logic [31:0]               r_count;
   logic                      r_int_pending;

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   logic [1:0] w_reg_sel;
   logic       w_wr_ctrl;
   logic       w_wr_preset;
   logic       w_enable;
   logic       w_mask;
   logic       w_reload;
   logic       w_count_zero;
   logic       w_unused_addr;

   assign w_reg_sel     = address[3:2];
   assign w_wr_ctrl     = writeEnable && (w_reg_sel == c_addr_ctrl);
   assign w_wr_preset   = writeEnable && (w_reg_sel == c_addr_preset);
   assign w_enable      = r_ctrl[c_ctrl_en_bit];
   assign w_mask        = r_ctrl[c_ctrl_im_bit];
   assign w_reload      = is_reload_mode(r_ctrl[c_ctrl_mode_msb:c_ctrl_mode_lsb]);
   assign w_count_zero  = (r_count == 32'd0);

   // Only the word index participates in decode; the rest of the bus address
   // is intentionally ignored.
   assign w_unused_addr = ^{address[31:4], address[1:0]};

   // Interrupt request is combinational so clearing IM drops it immediately
   assign irq = r_int_pending & w_mask;

   // Register file and timer FSM; a CTRL write overrides whatever the FSM
   // would have done in the same cycle, while a PRESET write never touches
   // the FSM (LOAD samples the pre-write PRESET value through the NBA).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= TIMER_IDLE;
         r_ctrl        <= '0;
         r_preset      <= 32'd0;
         r_count       <= 32'd0;
         r_int_pending <= 1'b0;
      end else begin
         if (w_wr_preset) begin
            r_preset <= writeData;
         end

         if (w_wr_ctrl) begin
            r_ctrl        <= writeData[c_ctrl_width-1:0];
            r_state       <= TIMER_IDLE;
            r_int_pending <= 1'b0;
         end else begin
            case (r_state)
               TIMER_IDLE: begin
                  if (w_enable) begin
                     r_state <= TIMER_LOAD;
                  end
               end

               TIMER_LOAD: begin
                  r_count <= r_preset;
                  r_state <= TIMER_CNT;
               end

               TIMER_CNT: begin
                  if (!w_enable) begin
                     r_state <= TIMER_IDLE;
                  end else if (!w_count_zero) begin
                     r_count <= r_count - 32'd1;
                  end else begin
                     r_int_pending <= 1'b1;
                     r_state       <= TIMER_INT;
                  end
               end

               TIMER_INT: begin
                  if (w_reload) begin
                     // Auto-reload: pending lasts exactly one cycle
                     r_int_pending <= 1'b0;
                     r_state       <= TIMER_LOAD;
                  end else begin
                     // One-shot: self-disable, pending held until CTRL write
                     r_ctrl[c_ctrl_en_bit] <= 1'b0;
                     r_state               <= TIMER_IDLE;
                  end
               end

               default: begin
                  r_state <= TIMER_IDLE;
               end
            endcase
         end
      end
   end

   // Zero-latency register read; unused offset returns zero
   always_comb begin
      readData = 32'd0;
      case (w_reg_sel)
         c_addr_ctrl:   readData = {{(32-c_ctrl_width){1'b0}}, r_ctrl};
         c_addr_preset: readData = r_preset;
         c_addr_count:  readData = r_count;
         default:       readData = 32'd0;
      endcase
   end

endmodule : timer_counter
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_counter
//  Purpose  : Self-checking bench for timer_counter. Expected COUNT, irq and
//             CTRL values come from a run-list model: each run is the
//             sequence PRESET..0 followed by an INT cycle and, in reload
//             mode, a LOAD cycle before the next run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_counter;

   localparam int MAXT = 256;

   logic        clk;
   logic        reset;
   logic [31:0] address;
   logic        writeEnable;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        irq;

   int checks;
   int errors;

   // Model state carried between scenarios
   int          m_count;
   int          m_preset;

   // Per-cycle expectations, index t = edges after the CTRL write edge
   int          exp_cnt  [0:MAXT-1];
   bit          exp_irq  [0:MAXT-1];
   bit          exp_enclr[0:MAXT-1];

   timer_counter dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .writeEnable (writeEnable),
      .writeData   (writeData),
      .readData    (readData),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus write captured on the next rising edge; returns 1 time unit after it
   task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
      address     = {28'h0, off, 2'b00};
      writeData   = data;
      writeEnable = 1'b1;
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      writeData   = 32'h0;
   endtask

   task automatic read_reg(input logic [1:0] off, output logic [31:0] v);
      address = {28'h0, off, 2'b00};
      #1;
      v = readData;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Halt the timer (COUNT holds) and program a new PRESET while idle
   task automatic setup(input int n);
      bus_write(2'd0, 32'h0);
      bus_write(2'd1, n);
      m_preset = n;
   endtask

   // Build expectations for a run started by a CTRL write at edge 0.
   // A PRESET write captured at edge mid_t affects every run whose LOAD
   // edge comes strictly later.
   function automatic void build_model(input int n_old, input int n_new,
                                       input int mid_t, input logic [3:0] ctrl,
                                       input int cycles);
      int  pos;
      int  p;
      bit  reload;
      bit  im;
      reload = (ctrl[2:1] == 2'b01);
      im     = ctrl[3];
      for (int t = 0; t <= cycles; t++) begin
         exp_cnt[t]   = m_count;
         exp_irq[t]   = 1'b0;
         exp_enclr[t] = 1'b0;
      end
      if (ctrl[0]) begin
         pos = 2;
         while (pos <= cycles) begin
            p = (mid_t >= 0 && pos > mid_t) ? n_new : n_old;
            for (int k = p; k >= 0 && pos <= cycles; k--) begin
               exp_cnt[pos] = k;
               pos++;
            end
            if (pos <= cycles) begin
               exp_cnt[pos] = 0;
               exp_irq[pos] = im;
               pos++;
            end
            if (reload) begin
               if (pos <= cycles) begin
                  exp_cnt[pos] = 0;
                  pos++;
               end
            end else begin
               while (pos <= cycles) begin
                  exp_cnt[pos]   = 0;
                  exp_irq[pos]   = im;
                  exp_enclr[pos] = 1'b1;
                  pos++;
               end
            end
         end
      end
   endfunction

   // Start a run with a CTRL write and check COUNT, irq and CTRL each cycle
   task automatic run_check(input string name, input int n_new, input int mid_t,
                            input logic [3:0] ctrl, input int cycles);
      logic [31:0] v;
      logic [31:0] exp_ctrl;
      build_model(m_preset, n_new, mid_t, ctrl, cycles);
      bus_write(2'd0, {$urandom() & 32'hFFFF_FFF0} | {28'h0, ctrl});
      for (int t = 0; t <= cycles; t++) begin
         if (t > 0) begin
            if (t == mid_t) begin
               address     = {28'h0, 2'd1, 2'b00};
               writeData   = n_new;
               writeEnable = 1'b1;
            end
            tick();
            writeEnable = 1'b0;
         end
         read_reg(2'd2, v);
         checks++;
         if (v !== 32'(exp_cnt[t])) begin
            errors++;
            $display("FAIL %s count t=%0d got %0d expected %0d", name, t, v, exp_cnt[t]);
         end
         checks++;
         if (irq !== exp_irq[t]) begin
            errors++;
            $display("FAIL %s irq t=%0d got %b expected %b", name, t, irq, exp_irq[t]);
         end
         read_reg(2'd0, v);
         exp_ctrl = {28'h0, exp_enclr[t] ? (ctrl & 4'hE) : ctrl};
         checks++;
         if (v !== exp_ctrl) begin
            errors++;
            $display("FAIL %s ctrl t=%0d got %h expected %h", name, t, v, exp_ctrl);
         end
      end
      m_count = exp_cnt[cycles];
      if (mid_t >= 1 && mid_t <= cycles) m_preset = n_new;
      read_reg(2'd1, v);
      checks++;
      if (v !== 32'(m_preset)) begin
         errors++;
         $display("FAIL %s preset got %0d expected %0d", name, v, m_preset);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset       = 1'b1;
      writeEnable = 1'b0;
      writeData   = 32'h0;
      address     = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         read_reg(2'(i), v);
         checks++;
         if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset read off=%0d got %h expected 0", i, v);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset irq got %b expected 0", irq);
      end
      m_count  = 0;
      m_preset = 0;
   endtask

   task automatic test_one_shot();
      logic [31:0] v;
      setup(5);
      run_check("oneshot", 5, -1, 4'h9, 12);
      bus_write(2'd0, 32'h8);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_clear irq got %b expected 0", irq);
      end
      read_reg(2'd0, v);
      checks++;
      if (v !== 32'h8) begin
         errors++;
         $display("FAIL oneshot_clear ctrl got %h expected 8", v);
      end
   endtask

   task automatic test_auto_reload();
      setup(3);
      run_check("reload", 3, -1, 4'hB, 26);
   endtask

   task automatic test_mask();
      setup(2);
      run_check("mask", 2, -1, 4'h1, 10);
      bus_write(2'd0, 32'h8);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_clear irq i=%0d got %b expected 0", i, irq);
         end
         tick();
      end
   endtask

   task automatic test_collision();
      logic [31:0] v;
      logic [31:0] wv;
      for (int j = 0; j < 2; j++) begin
         wv = (j == 0) ? 32'h0 : 32'h8;
         setup(2);
         run_check("collision_pre", 2, -1, 4'h9, 4);
         bus_write(2'd0, wv);
         for (int i = 0; i < 4; i++) begin
            read_reg(2'd2, v);
            checks++;
            if (v !== 32'h0 || irq !== 1'b0) begin
               errors++;
               $display("FAIL collision wv=%h i=%0d count=%0d irq=%b expected count 0 irq 0",
                        wv, i, v, irq);
            end
            read_reg(2'd0, v);
            checks++;
            if (v !== wv) begin
               errors++;
               $display("FAIL collision ctrl i=%0d got %h expected %h", i, v, wv);
            end
            tick();
         end
         m_count = 0;
      end
   endtask

   task automatic test_preset_mid();
      setup(10);
      run_check("preset_mid", 2, 6, 4'hB, 30);
      setup(4);
      run_check("preset_at_load", 9, 2, 4'h3, 25);
      setup(0);
      run_check("preset_zero", 0, -1, 4'hB, 12);
   endtask

   task automatic test_random();
      int          n;
      int          n2;
      int          mid;
      int          cyc;
      logic [3:0]  c;
      for (int it = 0; it < 12; it++) begin
         n   = $urandom_range(0, 12);
         n2  = $urandom_range(0, 12);
         cyc = $urandom_range(5, 45);
         c   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) c[0] = 1'b1;
         mid = ($urandom_range(0, 1) == 1) ? $urandom_range(1, cyc) : -1;
         setup(n);
         run_check("random", n2, mid, c, cyc);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      writeEnable = 1'b0;
      writeData   = 32'h0;
      address     = 32'h0;
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_mask();
      test_collision();
      test_preset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_timer_counter
`default_nettype wire
